// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment result display.
`default_nettype none

package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] DIG_UNITS    = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;
    localparam logic [1:0] DIG_OPCODE   = 2'd3;

    function automatic logic [6:0] glyph(input logic [3:0] digit);
        case (digit)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd8.sv
// Sequential double-dabble: 8-bit binary to three BCD digits, one bit per shift_en cycle.
`default_nettype none

module bin2bcd8
    import seg7_pkg::*;
(
    input  logic       Clk_100M,
    input  logic       rst,
    input  logic       start,
    input  logic       shift_en,
    input  logic [7:0] bin_in,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       last_shift
);

    logic [7:0]  bin_sr;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic [2:0]  shift_cnt;

    function automatic logic [3:0] add3(input logic [3:0] n);
        add3 = (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign bcd_adj    = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    assign last_shift = (shift_cnt == 3'd7);

    always_ff @(posedge Clk_100M) begin
        if (rst) begin
            bin_sr    <= '0;
            bcd       <= '0;
            shift_cnt <= '0;
        end else if (start) begin
            bin_sr    <= bin_in;
            bcd       <= '0;
            shift_cnt <= '0;
        end else if (shift_en) begin
            bcd       <= {bcd_adj[10:0], bin_sr[7]};
            bin_sr    <= {bin_sr[6:0], 1'b0};
            shift_cnt <= shift_cnt + 3'd1;
        end
    end

    assign hundreds = bcd[11:8];
    assign tens     = bcd[7:4];
    assign units    = bcd[3:0];

endmodule

`default_nettype wire

// File: rtl/seg7_result_display.sv
// Result/opcode display driver: load handshake, BCD conversion, 4-digit scan.
// SEG7_LZB_EN: when defined, blank leading zeros of the result digits.
`default_nettype none

module seg7_result_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       Clk_100M,
    input  logic       rst,
    input  logic [7:0] result_i,
    input  logic [2:0] opcode_i,
    input  logic       load_i,
    output logic       busy_o,
    output logic [3:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t      state;
    logic [2:0]  opcode_cap;
    logic [3:0]  disp_hund;
    logic [3:0]  disp_tens;
    logic [3:0]  disp_units;
    logic [2:0]  disp_op;

    logic        start;
    logic        shift_en;
    logic        last_shift;
    logic [3:0]  bcd_hund;
    logic [3:0]  bcd_tens;
    logic [3:0]  bcd_units;

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic [6:0]       digit_seg;
    logic [3:0]       digit_an;

    assign start    = (state == IDLE) && load_i;
    assign shift_en = (state == SHIFT);
    assign busy_o   = (state != IDLE);

    bin2bcd8 u_bin2bcd8 (
        .Clk_100M   (Clk_100M),
        .rst        (rst),
        .start      (start),
        .shift_en   (shift_en),
        .bin_in     (result_i),
        .hundreds   (bcd_hund),
        .tens       (bcd_tens),
        .units      (bcd_units),
        .last_shift (last_shift)
    );

    // Display registers are touched only in COMMIT so a half-converted value never shows.
    always_ff @(posedge Clk_100M) begin
        if (rst) begin
            state      <= IDLE;
            opcode_cap <= '0;
            disp_hund  <= '0;
            disp_tens  <= '0;
            disp_units <= '0;
            disp_op    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_i) begin
                        opcode_cap <= opcode_i;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_shift) state <= COMMIT;
                end
                COMMIT: begin
                    disp_hund  <= bcd_hund;
                    disp_tens  <= bcd_tens;
                    disp_units <= bcd_units;
                    disp_op    <= opcode_cap;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk_100M) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_comb begin
        digit_seg = SEG_BLANK;
        digit_an  = 4'b0001 << digit_idx;
        case (digit_idx)
            DIG_OPCODE:   digit_seg = glyph({1'b0, disp_op});
`ifdef SEG7_LZB_EN
            DIG_HUNDREDS: digit_seg = (disp_hund == 4'd0) ? SEG_BLANK : glyph(disp_hund);
            DIG_TENS:     digit_seg = (disp_hund == 4'd0 && disp_tens == 4'd0) ?
                                      SEG_BLANK : glyph(disp_tens);
`else
            DIG_HUNDREDS: digit_seg = glyph(disp_hund);
            DIG_TENS:     digit_seg = glyph(disp_tens);
`endif
            default:      digit_seg = glyph(disp_units);
        endcase
    end

    // Anodes and segments share one register stage so they switch on the same edge.
    always_ff @(posedge Clk_100M) begin
        if (rst) begin
            an_o  <= ACTIVE_LOW ? 4'hF  : 4'h0;
            seg_o <= ACTIVE_LOW ? 7'h7F : 7'h00;
            dp_o  <= ACTIVE_LOW;
        end else begin
            an_o  <= ACTIVE_LOW ? ~digit_an  : digit_an;
            seg_o <= ACTIVE_LOW ? ~digit_seg : digit_seg;
            dp_o  <= ACTIVE_LOW ^ (digit_idx == DIG_OPCODE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_result_display.sv
// Directed self-checking bench for seg7_result_display (REFRESH_DIV=4, ACTIVE_LOW=1).
`default_nettype none

module tb_seg7_result_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] result = '0;
    logic [2:0] opcode = '0;
    logic       load = 1'b0;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_result_display #(
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .Clk_100M (clk),
        .rst      (rst),
        .result_i (result),
        .opcode_i (opcode),
        .load_i   (load),
        .busy_o   (busy),
        .an_o     (an),
        .seg_o    (seg),
        .dp_o     (dp)
    );

    always #5 clk = ~clk;

`ifdef SEG7_LZB_EN
    localparam logic [6:0] LZ_GLYPH = 7'h7F;
`else
    localparam logic [6:0] LZ_GLYPH = 7'h40;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] r, input logic [2:0] op);
        result = r;
        opcode = op;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 30 && busy !== 1'b0; k++) tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy_o still %b after 30 cycles, required 0", name, busy);
        end
    endtask

    // Returns seg/dp seen while the requested digit is enabled, or X on timeout.
    task automatic grab_digit(input int idx, output logic [6:0] s, output logic d);
        logic [3:0] want;
        want = ~(4'b0001 << idx);
        s = 'x;
        d = 1'bx;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (an === want) begin
                s = seg;
                d = dp;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks += 4;
        if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b required 1111", an); end
        if (seg !== 7'h7F)  begin n_fail++; $display("FAIL reset_seg: got %h required 7f", seg); end
        if (dp !== 1'b1)    begin n_fail++; $display("FAIL reset_dp: got %b required 1", dp); end
        if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_conversion();
        int hi_cycles;
        logic [6:0] s;
        logic d;
        do_load(8'd255, 3'd4);
        hi_cycles = 0;
        for (int k = 0; k < 20 && busy === 1'b1; k++) begin
            hi_cycles++;
            tick();
        end
        n_checks++;
        if (hi_cycles != 9) begin
            n_fail++;
            $display("FAIL conv_busy_len: got %0d cycles required 9", hi_cycles);
        end
        grab_digit(3, s, d);
        n_checks += 2;
        if (s !== 7'h19) begin n_fail++; $display("FAIL conv_dig3: got %h required 19", s); end
        if (d !== 1'b0)  begin n_fail++; $display("FAIL conv_dp3: got %b required 0", d); end
        grab_digit(2, s, d);
        n_checks++;
        if (s !== 7'h24) begin n_fail++; $display("FAIL conv_dig2: got %h required 24", s); end
        grab_digit(1, s, d);
        n_checks += 2;
        if (s !== 7'h12) begin n_fail++; $display("FAIL conv_dig1: got %h required 12", s); end
        if (d !== 1'b1)  begin n_fail++; $display("FAIL conv_dp1: got %b required 1", d); end
        grab_digit(0, s, d);
        n_checks++;
        if (s !== 7'h12) begin n_fail++; $display("FAIL conv_dig0: got %h required 12", s); end
    endtask

    task automatic test_blanking();
        logic [6:0] s;
        logic d;
        do_load(8'd7, 3'd1);
        wait_idle("blank_idle");
        grab_digit(2, s, d);
        n_checks++;
        if (s !== LZ_GLYPH) begin n_fail++; $display("FAIL blank_dig2: got %h required %h", s, LZ_GLYPH); end
        grab_digit(1, s, d);
        n_checks++;
        if (s !== LZ_GLYPH) begin n_fail++; $display("FAIL blank_dig1: got %h required %h", s, LZ_GLYPH); end
        grab_digit(0, s, d);
        n_checks++;
        if (s !== 7'h78) begin n_fail++; $display("FAIL blank_dig0: got %h required 78", s); end
        grab_digit(3, s, d);
        n_checks++;
        if (s !== 7'h79) begin n_fail++; $display("FAIL blank_op: got %h required 79", s); end
    endtask

    task automatic test_busy_drop();
        logic [6:0] s;
        logic d;
        do_load(8'd100, 3'd2);
        tick();
        tick();
        do_load(8'd42, 3'd2);
        wait_idle("drop_idle1");
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_no_retrigger: busy got %b required 0", busy); end
        grab_digit(2, s, d);
        n_checks++;
        if (s !== 7'h79) begin n_fail++; $display("FAIL drop_dig2: got %h required 79", s); end
        grab_digit(1, s, d);
        n_checks++;
        if (s !== 7'h40) begin n_fail++; $display("FAIL drop_dig1: got %h required 40", s); end
        grab_digit(0, s, d);
        n_checks++;
        if (s !== 7'h40) begin n_fail++; $display("FAIL drop_dig0: got %h required 40", s); end
        do_load(8'd42, 3'd2);
        wait_idle("drop_idle2");
        grab_digit(2, s, d);
        n_checks++;
        if (s !== LZ_GLYPH) begin n_fail++; $display("FAIL reload_dig2: got %h required %h", s, LZ_GLYPH); end
        grab_digit(1, s, d);
        n_checks++;
        if (s !== 7'h19) begin n_fail++; $display("FAIL reload_dig1: got %h required 19", s); end
        grab_digit(0, s, d);
        n_checks++;
        if (s !== 7'h24) begin n_fail++; $display("FAIL reload_dig0: got %h required 24", s); end
    endtask

    task automatic test_scan_order();
        logic [3:0] prev;
        logic [3:0] exp_an [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        logic       exp_dp [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        bit found;
        found = 1'b0;
        prev = an;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (an === 4'b1110 && prev !== 4'b1110) found = 1'b1;
            prev = an;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL scan_sync: no 1110 slot start seen, an_o=%b", an);
        end else begin
            for (int step = 0; step < 5; step++) begin
                for (int c = 0; c < 4; c++) begin
                    if (step != 0 || c != 0) tick();
                    n_checks += 2;
                    if (an !== exp_an[step]) begin
                        n_fail++;
                        $display("FAIL scan_an step%0d cyc%0d: got %b required %b", step, c, an, exp_an[step]);
                    end
                    if (dp !== exp_dp[step]) begin
                        n_fail++;
                        $display("FAIL scan_dp step%0d cyc%0d: got %b required %b", step, c, dp, exp_dp[step]);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [6:0] s;
        logic d;
        do_load(8'd200, 3'd3);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %b required 0", busy); end
        if (an !== 4'b1111) begin n_fail++; $display("FAIL mrst_an: got %b required 1111", an); end
        if (seg !== 7'h7F)  begin n_fail++; $display("FAIL mrst_seg: got %h required 7f", seg); end
        if (dp !== 1'b1)    begin n_fail++; $display("FAIL mrst_dp: got %b required 1", dp); end
        rst = 1'b0;
        repeat (12) tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_no_commit_busy: got %b required 0", busy); end
        grab_digit(3, s, d);
        n_checks++;
        if (s !== 7'h40) begin n_fail++; $display("FAIL mrst_dig3: got %h required 40", s); end
        grab_digit(2, s, d);
        n_checks++;
        if (s !== LZ_GLYPH) begin n_fail++; $display("FAIL mrst_dig2: got %h required %h", s, LZ_GLYPH); end
        grab_digit(1, s, d);
        n_checks++;
        if (s !== LZ_GLYPH) begin n_fail++; $display("FAIL mrst_dig1: got %h required %h", s, LZ_GLYPH); end
        grab_digit(0, s, d);
        n_checks++;
        if (s !== 7'h40) begin n_fail++; $display("FAIL mrst_dig0: got %h required 40", s); end
    endtask

    initial begin
        tick();
        test_reset();
        test_conversion();
        test_blanking();
        test_busy_drop();
        test_scan_order();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg7_result_display.md
# seg7_result_display

Output-side display driver for the button/switch ALU board. It accepts an 8-bit unsigned result and a 3-bit opcode through a load/busy handshake. A sequential double-dabble converts the result to three BCD digits. A four-digit multiplexed seven-segment display is then scanned: digit 3 shows the opcode and digits 2..0 show the result in decimal. It sits between the ALU result register and the board's anode/segment pins.

## Interface
- REFRESH_DIV, 100000: Clk_100M cycles per digit slot (1 kHz digit rate).
- ACTIVE_LOW, 1: when 1, an_o, seg_o and dp_o are active-low; when 0, active-high.

- Clk_100M  in  1  system clock, 100 MHz.
- rst  in  1  reset, synchronous, active-high.
- result_i  in  8  unsigned value to display (0..255).
- opcode_i  in  3  opcode to display on digit 3 (0..7).
- load_i  in  1  capture request; sampled only when busy_o=0.
- busy_o  out  1  conversion in progress; load_i is ignored while high.
- an_o  out  4  digit enables; an_o[k] drives digit k.
- seg_o  out  7  segments {g,f,e,d,c,b,a}.
- dp_o  out  1  decimal point; lit only while digit 3 is enabled.

## Operation
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE + load_i=1: capture result_i and opcode_i, clear the BCD scratch registers, go to SHIFT.
  - SHIFT: runs for exactly 8 cycles. Each cycle, add 3 to any BCD nibble ≥5, then shift left one bit with the next result MSB entering.
  - COMMIT: copy hundreds/tens/units and the captured opcode into the display registers, return to IDLE.
- busy_o=1 in SHIFT and COMMIT, 0 in IDLE.
- Display registers change only in COMMIT, so the displayed value never shows a partial conversion.
- Scan:
  - A refresh counter counts 0..REFRESH_DIV-1 and then wraps.
  - On wrap, the 2-bit digit index advances 0→1→2→3→0.
  - Exactly one an_o bit is enabled at any time.
- Digit content:
  - Digit 3: opcode value (0..7).
  - Digit 2: hundreds. Digit 1: tens. Digit 0: units.
- Segment patterns are standard decimal glyphs. A blank digit drives all segments off.
- Result values are always treated as unsigned: a wrapped subtraction such as 8'hFD displays as 253.
- Reset values:
  - busy_o=0.
  - an_o, seg_o and dp_o all inactive (all ones when ACTIVE_LOW=1).
  - FSM in IDLE; display registers, refresh counter and digit index at 0.
- Reset in SHIFT or COMMIT aborts the conversion. No commit occurs.

## Timing
- load_i accepted on edge N (FSM in IDLE, load_i=1).
- busy_o is high from after edge N through edge N+9; it is low after edge N+9.
- The display registers update on edge N+9, so a new value is visible from the next digit slot onward.
- Any load_i pulse during busy is dropped. A load_i held high is re-accepted on the first IDLE edge.
- an_o and seg_o are registered. They change together, one cycle after the digit index changes, so no ghosting occurs between digits.
- The refresh counter runs continuously and is independent of conversions.

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking.
  - Digit 2 is blank when hundreds=0.
  - Digit 1 is blank when hundreds=0 and tens=0.
  - Digit 0 always shows, including for a result of 0.
- SEG7_LZB_EN undefined: all three result digits always show, e.g. "007".
- The opcode digit is never blanked in either mode.

## Structure
- Package seg7_pkg holds:
  - FSM state enum (IDLE, SHIFT, COMMIT).
  - Active-high glyph constants for 0..9 and SEG_BLANK.
  - Digit index constants DIG_UNITS, DIG_TENS, DIG_HUNDREDS, DIG_OPCODE.
- Sub-module bin2bcd8 holds the sequential double-dabble engine and its shift counter. The top level keeps the handshake, display registers, scan counter and output polarity.

## Test plan
- Reset: assert rst for 3 cycles → an_o=4'b1111, seg_o=7'h7F, dp_o=1, busy_o=0 (ACTIVE_LOW=1).
- Conversion: result_i=8'd255, opcode_i=3'd4, one-cycle load_i → busy_o high for exactly 9 cycles. Scan with REFRESH_DIV=4 then shows digits 3..0 = 4,2,5,5. While digit 1 is enabled, seg_o=7'h12.
- Blanking: result_i=8'd7 → with SEG7_LZB_EN, digits 2 and 1 drive seg_o=7'h7F and digit 0 drives 7'h78. Without the macro, digits 2 and 1 drive 7'h40.
- Busy drop: load 8'd100, then load 8'd42 three cycles later → display shows 100. A subsequent load after busy_o falls shows 042 (or " 42" with blanking).
- Scan order: REFRESH_DIV=4 → an_o cycles 1110, 1101, 1011, 0111, 1110 with 4 cycles per step. dp_o=0 only with an_o=0111.
- Mid-conversion reset: assert rst 4 cycles after load_i → busy_o=0 on the next edge, all outputs inactive. After release, digits show 0,0,0,0 (or 0 with blanking).
